// File: rtl/i2c_master_phy.sv
// Bit-level I2C master: turns start/send/receive/stop requests into open-drain SCL/SDA quarter-phase waveforms.
// Optional build macro I2C_CLOCK_STRETCH_EN lets a slave stretch SCL by holding scl_i low.
module i2c_master_phy #(
    parameter int unsigned QDIV = 250,
    parameter int unsigned QW   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       send,
    input  logic       receive,
    input  logic       rx_nack,
    input  logic       stop,
    input  logic [7:0] datasend,
    output logic       sended,
    output logic [7:0] datareceive,
    output logic       received,
    output logic       nack,
    output logic       isReady,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_i,
    input  logic       sda_i
);

    typedef enum logic [3:0] {
        IDLE, START, HOLD, TX_BIT, TX_ACK, RX_BIT, RX_ACK, RSTART, STOP
    } state_t;

    state_t         state, stateNext;
    logic [QW-1:0]  cnt;
    logic [1:0]     q;
    logic [2:0]     bitIdx;
    logic [7:0]     txData;
    logic [7:0]     shiftReg;
    logic           rxNackLat;
    logic           counting;
    logic           stretch;
    logic           qtick;
    logic           lastQ;

    assign counting = (state != IDLE) && (state != HOLD);

`ifdef I2C_CLOCK_STRETCH_EN
    assign stretch = ~scl_oe & ~scl_i;
`else
    // pin sense is deliberately ignored; timing is purely counter based
    assign stretch = scl_i & 1'b0;
`endif

    assign qtick = counting && !stretch && (cnt == QW'(QDIV - 1));
    assign lastQ = qtick && (q == 2'd3);

    assign isReady  = (state == IDLE);
    assign busy     = ~isReady;
    assign sended   = (state == TX_ACK);
    assign received = (state == RX_ACK);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            q           <= '0;
            bitIdx      <= '0;
            txData      <= '0;
            shiftReg    <= '0;
            rxNackLat   <= 1'b0;
            nack        <= 1'b0;
            datareceive <= '0;
        end else begin
            state <= stateNext;

            if (!counting || stretch || qtick) cnt <= '0;
            else                               cnt <= cnt + 1'b1;

            if (!counting)  q <= '0;
            else if (qtick) q <= q + 2'd1;

            if (state == HOLD && !stop && !start) begin
                if (send) begin
                    txData <= datasend;
                    bitIdx <= 3'd7;
                end else if (receive) begin
                    rxNackLat <= rx_nack;
                    bitIdx    <= 3'd7;
                end
            end

            if ((state == TX_BIT || state == RX_BIT) && lastQ)
                bitIdx <= bitIdx - 3'd1;

            if (state == TX_ACK && qtick && q == 2'd2)
                nack <= sda_i;

            if (state == RX_BIT && qtick && q == 2'd1)
                shiftReg[bitIdx] <= sda_i;

            // bit 0 was sampled at the end of q1, so shiftReg is complete here
            if (state == RX_BIT && lastQ && bitIdx == 3'd0)
                datareceive <= shiftReg;
        end
    end

    always_comb begin
        stateNext = state;
        scl_oe    = 1'b0;
        sda_oe    = 1'b0;
        case (state)
            IDLE: begin
                if (start) stateNext = START;
            end
            START: begin
                scl_oe = (q >= 2'd2);
                sda_oe = (q != 2'd0);
                if (lastQ) stateNext = HOLD;
            end
            HOLD: begin
                scl_oe = 1'b1;
                if (stop)         stateNext = STOP;
                else if (start)   stateNext = RSTART;
                else if (send)    stateNext = TX_BIT;
                else if (receive) stateNext = RX_BIT;
            end
            TX_BIT: begin
                scl_oe = (q == 2'd0) || (q == 2'd3);
                sda_oe = ~txData[bitIdx];
                if (lastQ && bitIdx == 3'd0) stateNext = TX_ACK;
            end
            TX_ACK: begin
                scl_oe = (q == 2'd0) || (q == 2'd3);
                if (lastQ) stateNext = HOLD;
            end
            RX_BIT: begin
                scl_oe = (q == 2'd0) || (q == 2'd3);
                if (lastQ && bitIdx == 3'd0) stateNext = RX_ACK;
            end
            RX_ACK: begin
                scl_oe = (q == 2'd0) || (q == 2'd3);
                sda_oe = ~rxNackLat;
                if (lastQ) stateNext = HOLD;
            end
            RSTART: begin
                scl_oe = (q == 2'd0) || (q == 2'd3);
                sda_oe = (q >= 2'd2);
                if (lastQ) stateNext = HOLD;
            end
            STOP: begin
                scl_oe = (q == 2'd0);
                sda_oe = (q <= 2'd1);
                if (lastQ) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_i2c_master_phy.sv
// Self-checking bench for i2c_master_phy with QDIV=4 (16 clk per SCL bit) and an open-drain slave model.
module tb_i2c_master_phy;

    localparam int unsigned QDIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0, send = 1'b0, receive = 1'b0, rx_nack = 1'b0, stop = 1'b0;
    logic [7:0] datasend = '0;
    logic [7:0] datareceive;
    logic       sended, received, nack, isReady, busy, scl_oe, sda_oe;
    logic       scl_i, sda_i;
    logic       slaveScl = 1'b0, slaveSda = 1'b0;

    int tests = 0;
    int fails = 0;

    assign scl_i = ~scl_oe & ~slaveScl;
    assign sda_i = ~sda_oe & ~slaveSda;

    i2c_master_phy #(.QDIV(QDIV), .QW(16)) dut (
        .clk(clk), .reset(reset), .start(start), .send(send), .receive(receive),
        .rx_nack(rx_nack), .stop(stop), .datasend(datasend), .sended(sended),
        .datareceive(datareceive), .received(received), .nack(nack),
        .isReady(isReady), .busy(busy), .scl_oe(scl_oe), .sda_oe(sda_oe),
        .scl_i(scl_i), .sda_i(sda_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rd;
        logic [7:0] data;
        logic       flag;
        logic       expBit;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic goHold(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        check({tag, "_hold"}, {busy, scl_oe, sda_oe}, 3'b110);
    endtask

    // st > 0: slave holds SCL low for st cycles from the moment bit 3 releases SCL
    task automatic doWrite(input logic [7:0] d, input logic slvNack, input int st,
                           input logic expNack, input string tag);
        logic [7:0] got;
        int n;
        got = '0;
        datasend = d;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        for (int c = 0; c <= 144 + st; c++) begin
            if (c > 0) @(negedge clk);
            slaveScl = (c >= 68) && (c < 68 + st);
            n = (c < 68) ? c : ((c < 68 + st) ? -1 : c - st);
            slaveSda = !slvNack && (n >= 128) && (n < 144);
            for (int k = 0; k < 8; k++)
                if (n == 16 * k + 8) got[7-k] = sda_i;
            if (n == 127) check({tag, "_sended_pre"}, sended, 1'b0);
            if (n == 128) check({tag, "_sended_rise"}, sended, 1'b1);
            if (n == 143) check({tag, "_sended_hi"}, sended, 1'b1);
            if (n == 144) begin
                check({tag, "_sended_fall"}, sended, 1'b0);
                check({tag, "_nack"}, nack, expNack);
            end
        end
        slaveSda = 1'b0;
        slaveScl = 1'b0;
        check({tag, "_byte"}, got, d);
    endtask

    task automatic doRead(input logic [7:0] d, input logic rxn, input logic expAckSda,
                          input string tag);
        rx_nack = rxn;
        receive = 1'b1;
        @(negedge clk);
        receive = 1'b0;
        rx_nack = 1'b0;
        for (int c = 0; c <= 144; c++) begin
            if (c > 0) @(negedge clk);
            slaveSda = (c < 128) ? ~d[7 - c / 16] : 1'b0;
            if (c == 127) check({tag, "_recv_pre"}, received, 1'b0);
            if (c == 128) begin
                check({tag, "_recv_rise"}, received, 1'b1);
                check({tag, "_data"}, datareceive, d);
            end
            if (c == 136) check({tag, "_ack_sda"}, {scl_i, sda_i}, {1'b1, expAckSda});
            if (c == 144) check({tag, "_recv_fall"}, {received, sda_oe}, 2'b00);
        end
        slaveSda = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 8'hEE, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'hA5, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 8'h5A, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        check("reset_outs", {isReady, busy, scl_oe, sda_oe, sended, received, nack}, 7'b1000000);
        check("reset_data", datareceive, 8'h00);
        reset = 1'b1;
        @(negedge clk);

        // START: level held two cycles from IDLE
        start = 1'b1;
        @(negedge clk);
        check("start_ready_fall", {isReady, busy, scl_oe, sda_oe}, 4'b0100);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("start_sda_low", {scl_oe, sda_oe}, 2'b01);
        repeat (4) @(negedge clk);
        check("start_scl_low", {scl_oe, sda_oe}, 2'b11);
        repeat (7) @(negedge clk);
        check("start_q3", {scl_oe, sda_oe}, 2'b11);
        @(negedge clk);
        check("start_hold", {scl_oe, sda_oe}, 2'b10);
        repeat (10) @(negedge clk);
        check("hold_wait", {busy, scl_oe, sda_oe, sended, received}, 5'b11000);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].rd)
                doRead(vecs[i].data, vecs[i].flag, vecs[i].expBit, $sformatf("v%0d", i));
            else
                doWrite(vecs[i].data, vecs[i].flag, 0, vecs[i].expBit, $sformatf("v%0d", i));
        end

        // STOP after the NACKed write
        check("pre_stop_nack", nack, 1'b1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_q0", {scl_oe, sda_oe}, 2'b11);
        repeat (4) @(negedge clk);
        check("stop_q1", {scl_oe, sda_oe}, 2'b01);
        repeat (4) @(negedge clk);
        check("stop_sda_rise", {scl_i, sda_i}, 2'b11);
        repeat (7) @(negedge clk);
        check("stop_q3_busy", isReady, 1'b0);
        @(negedge clk);
        check("stop_idle", {isReady, busy}, 2'b10);

        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        @(negedge clk);
        check("idle_send_ignored", {isReady, scl_oe, sda_oe}, 3'b100);

        // repeated START from HOLD
        goHold("rs");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rs_q0", {scl_oe, sda_oe}, 2'b10);
        repeat (4) @(negedge clk);
        check("rs_q1", {scl_oe, sda_oe}, 2'b00);
        repeat (4) @(negedge clk);
        check("rs_q2", {scl_oe, sda_oe}, 2'b01);
        repeat (4) @(negedge clk);
        check("rs_q3", {scl_oe, sda_oe}, 2'b11);
        repeat (4) @(negedge clk);
        check("rs_hold", {busy, scl_oe, sda_oe}, 3'b110);

        // coincident stop/start/send: stop wins
        datasend = 8'hFF;
        stop = 1'b1;
        start = 1'b1;
        send = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        start = 1'b0;
        send = 1'b0;
        repeat (4) @(negedge clk);
        check("prio_stop", {scl_oe, sda_oe}, 2'b01);
        repeat (12) @(negedge clk);
        check("prio_idle", isReady, 1'b1);

        // reset in the middle of a transmitted bit
        goHold("rst");
        datasend = 8'hAA;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_mid_bit", {scl_oe, sda_oe}, 2'b01);
        reset = 1'b0;
        @(negedge clk);
        check("rst_release", {scl_oe, sda_oe, isReady, busy, sended}, 5'b00100);
        reset = 1'b1;
        @(negedge clk);
        check("rst_idle", {isReady, scl_oe, sda_oe}, 3'b100);

`ifdef I2C_CLOCK_STRETCH_EN
        goHold("str");
        doWrite(8'hEE, 1'b0, 40, 1'b0, "str");
`endif

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
